wb_regfile_slave: RTL
=====================

# wb_regfile_slave

Wishbone pipelined slave (responder) that terminates the team's `wishbone_if` master transactions into a bank of `NUM_REGS` read/write control registers. It decodes byte addresses, applies byte-lane writes, returns read data, and flags illegal accesses with `err`. It supports a programmable number of wait states and holds `stall` while a transfer is outstanding. It sits behind the bus master and exposes the register contents to the datapath in parallel.

## Interface
- `DATA_WIDTH`, 32, data bus width in bits; multiple of 8.
- `ADDR_WIDTH`, 32, byte address width.
- `NUM_REGS`, 16, number of data-wide registers; power of two, ≥2.
- `WAIT_STATES`, 0, extra cycles inserted before ack/err; range 0..15.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `cyc` input 1: bus cycle valid.
- `stb` input 1: strobe / request valid.
- `we` input 1: 1 = write, 0 = read.
- `addr` input ADDR_WIDTH: byte address.
- `wdata` input DATA_WIDTH: write data.
- `sel` input DATA_WIDTH/8: byte-lane enables.
- `stall` output 1: request not accepted this cycle.
- `ack` output 1: normal termination, one-cycle pulse.
- `rdata` output DATA_WIDTH: read data, valid only while `ack`=1 for a read; 0 otherwise.
- `err` output 1: error termination, one-cycle pulse.
- `regs_out` output NUM_REGS*DATA_WIDTH: flattened register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `wr_pulse` output NUM_REGS: one-hot one-cycle pulse marking the register written.

## Operation
- **Reset values.** On reset, all registers, `regs_out`, `rdata`, `ack`, `err`, `wr_pulse` and `stall` are 0. The FSM enters IDLE and the wait counter is cleared.
- **States.**
  - IDLE: `stall`=0. A request is accepted when `cyc & stb & !stall` is true. On acceptance, latch `we`, `addr`, `wdata` and `sel`.
    - If `WAIT_STATES`=0, go to RESP.
    - Otherwise load the counter with `WAIT_STATES` and go to WAIT.
  - WAIT: `stall`=1. The counter decrements each cycle. Go to RESP when it reaches 1.
    - If `cyc`=0 is sampled in WAIT, abort: return to IDLE, with no ack, no err and no register update.
  - RESP: `stall`=1. Exactly one of `ack`/`err` is high for this single cycle. Go to IDLE on the next edge, regardless of `cyc`.
- **Decode.** With `L` = log2(DATA_WIDTH/8) and `I` = log2(NUM_REGS), the word index is `addr[L +: I]`.
- **Error conditions.** An access is an error if either:
  - `addr[L-1:0]` ≠ 0 (misaligned), or
  - any bit of `addr` above `L+I-1` is set (out of range).
- **Error response.** An error access asserts `err` instead of `ack`, leaves the registers unchanged, and drives `rdata`=0.
- **Write.** Byte lane b of the target register takes `wdata[8b+7:8b]` iff `sel[b]`=1.
  - The update occurs on the edge entering RESP, so `regs_out` shows the new value while `ack` is high.
  - `wr_pulse[idx]` is high in the RESP cycle iff `sel`≠0.
  - A write with `sel`=0 is acked with no change and no pulse.
- **Read.** `rdata` is loaded from the target register on the edge entering RESP and ignores `sel`. It returns to 0 on the next edge.
- **Outstanding requests.** At most one transfer is outstanding. Requests presented while `stall`=1 are ignored and must be held by the master.

## Timing
- Let A be the accepting edge.
- `ack`/`err` is registered high after edge A+`WAIT_STATES`, so the master samples it at edge A+1+`WAIT_STATES`.
- Read latency is 1+`WAIT_STATES` cycles.
- `stall` is high from after edge A until after edge A+1+`WAIT_STATES`. The earliest next acceptance is edge A+2+`WAIT_STATES`.
- Throughput is one transfer per 2+`WAIT_STATES` cycles.
- `ack`, `err`, `rdata`, `stall` and `wr_pulse` are all registered outputs; none has a combinational path from inputs.
- Asynchronous `rst` mid-transfer immediately clears all outputs and registers. The in-flight access is dropped with no ack.
- `stb` held high after ack with `stall`=1 creates no second access. It is re-accepted only once `stall`=0.

## Test plan
- **Reset:** assert `rst` mid-WAIT → outputs go 0 asynchronously; all `regs_out` = 0; first access after release completes normally.
- **Write/read, `WAIT_STATES`=0:**
  - Write 0xDEADBEEF to addr 0x8 with `sel`=0xF → `ack` sampled at A+1; `wr_pulse`=0x0004; `regs_out[2]`=0xDEADBEEF.
  - Read addr 0x8 → `rdata`=0xDEADBEEF with `ack` at A+1.
- **Byte lanes:** reg 1 = 0x11223344; write 0xAABBCCDD with `sel`=0x5 → reg 1 = 0x11BB33DD.
- **Errors:**
  - Read addr 0x41 (misaligned) → `err`=1, `ack`=0, `rdata`=0.
  - Write addr 0x40 (out of range, NUM_REGS=16) → `err`=1, no `wr_pulse`, registers unchanged.
- **Wait states (`WAIT_STATES`=3):**
  - Read → `ack` sampled exactly at A+4; `stall` high A+1..A+4.
  - Back-to-back writes to regs 0 and 1 → second accepted at A+5.
- **Abort (`WAIT_STATES`=3):** write to reg 3, drop `cyc` at A+2 → no ack/err, reg 3 unchanged, FSM in IDLE with `stall`=0 by A+3.

Source files
------------

// File: rtl/wb_regfile_slave.sv
// Wishbone pipelined slave terminating bus cycles into a register bank.
// Optional wait states; error response on misaligned or out-of-range access.
module wb_regfile_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cyc,
  input  logic                           stb,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        sel,
  output logic                           stall,
  output logic                           ack,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           err,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int L  = $clog2(NB);
  localparam int I  = $clog2(NUM_REGS);

  localparam logic [ADDR_WIDTH-1:0] ONES      = '1;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ~(ONES << L);
  localparam logic [ADDR_WIDTH-1:0] HIGH_MASK = ONES << (L + I);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [3:0] cnt_q, cnt_d;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         sel_q, sel_d;

  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  stall_q, stall_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [NB-1:0]         req_sel;
  logic [I-1:0]          req_idx;
  logic                  req_bad;
  logic                  go_resp;

  // Live bus fields when responding straight from IDLE, latched ones otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_sel   = sel;
    end else begin
      req_we    = we_q;
      req_addr  = addr_q;
      req_wdata = wdata_q;
      req_sel   = sel_q;
    end
    req_idx = req_addr[L +: I];
    req_bad = (|(req_addr & LOW_MASK)) ||
              (|(req_addr & HIGH_MASK));
  end

  // Next-state, wait counter, request latch and response generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    go_resp    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cyc && stb && !stall_q) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          sel_d   = sel;
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!cyc) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          cnt_d   = '0;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (go_resp) begin
      if (req_bad) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (req_we) begin
          for (int b = 0; b < NB; b++) begin
            if (req_sel[b]) begin
              regs_d[req_idx][8*b +: 8] = req_wdata[8*b +: 8];
            end
          end
          wr_pulse_d[req_idx] = |req_sel;
        end else begin
          rdata_d = regs_q[req_idx];
        end
      end
    end

    stall_d = (state_d != S_IDLE);
  end

  // State, latched request, register bank and all bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign stall    = stall_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign wr_pulse = wr_pulse_q;

endmodule
